// File: rtl/calc_pkg.sv
// Shared definitions for the calculator key sequencer: key codes, FSM encoding,
// ALU op codes and the sign-magnitude operand format with its digit-entry helpers.
package calc_pkg;

  localparam logic [7:0] KEY_DIGIT_MAX = 8'h09;
  localparam logic [7:0] KEY_NEG       = 8'h0D;
  localparam logic [7:0] KEY_SEL_A     = 8'h0F;
  localparam logic [7:0] KEY_CLEAR     = 8'h10;
  localparam logic [7:0] KEY_POWER     = 8'h12;
  localparam logic [7:0] KEY_SEL_B     = 8'h13;
  localparam logic [7:0] KEY_ADD       = 8'h1A;
  localparam logic [7:0] KEY_SUB       = 8'h1E;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;

  typedef enum logic [3:0] {
    ST_OFF       = 4'd0,
    ST_IDLE      = 4'd1,
    ST_A_TENS    = 4'd2,
    ST_A_UNITS   = 4'd3,
    ST_A_SIGN    = 4'd4,
    ST_B_TENS    = 4'd5,
    ST_B_UNITS   = 4'd6,
    ST_B_SIGN    = 4'd7,
    ST_EXEC_WAIT = 4'd8
  } state_t;

  typedef struct packed {
    logic       sign;
    logic [6:0] mag;
  } smag_t;

  localparam smag_t OPND_BLANK = '{sign: 1'b1, mag: 7'h7F};
  localparam smag_t OPND_ZERO  = '{sign: 1'b0, mag: 7'd0};

  function automatic logic is_digit(input logic [7:0] c);
    return c <= KEY_DIGIT_MAX;
  endfunction

  // Recognised non-digit keys; anything else is ignored everywhere.
  function automatic logic is_command(input logic [7:0] c);
    return (c == KEY_NEG) || (c == KEY_SEL_A) || (c == KEY_CLEAR) ||
           (c == KEY_POWER) || (c == KEY_SEL_B) || (c == KEY_ADD) ||
           (c == KEY_SUB);
  endfunction

  function automatic smag_t smag_first(input logic [3:0] d);
    smag_t v;
    v.sign = 1'b0;
    v.mag  = 7'(d);
    return v;
  endfunction

  // Tens digit is at most 9 here, so 10*d+u never exceeds 99.
  function automatic smag_t smag_append(input smag_t x, input logic [3:0] u);
    smag_t v;
    v.sign = x.sign;
    v.mag  = 7'((x.mag * 7'd10) + 7'(u));
    return v;
  endfunction

  // Negative zero is never produced.
  function automatic smag_t smag_negate(input smag_t x);
    smag_t v;
    v.mag  = x.mag;
    v.sign = (x.mag != 7'd0) ? ~x.sign : 1'b0;
    return v;
  endfunction

endpackage

// File: rtl/calc_wait_timer.sv
// Loadable down-counter shared by the digit timeout and the ALU settle wait.
module calc_wait_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_count,
  output logic             o_done_c
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_count && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_done_c = (r_cnt == '0);

endmodule

// File: rtl/calc_key_sequencer.sv
// Remote-key sequencer for a two-operand calculator: digit entry, sign toggle,
// power control and ALU hand-off with a fixed settle wait.
module calc_key_sequencer
  import calc_pkg::*;
#(
  parameter int unsigned DIGIT_TIMEOUT = 50000000,
  parameter int unsigned ALU_LATENCY   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [7:0] cmd,
  input  logic [8:0] alu_result,
  output logic [7:0] operand_a,
  output logic [7:0] operand_b,
  output logic [2:0] alu_op,
  output logic [8:0] result,
  output logic       result_valid,
  output logic       power_on,
  output logic [3:0] state_dbg
);

  localparam int unsigned MAX_WAIT   = (DIGIT_TIMEOUT > ALU_LATENCY) ? DIGIT_TIMEOUT : ALU_LATENCY;
  localparam int unsigned CNT_W      = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  // Load one less so a digit is accepted on any of the DIGIT_TIMEOUT edges after the tens digit.
  localparam int unsigned DIGIT_LOAD = (DIGIT_TIMEOUT > 0) ? DIGIT_TIMEOUT - 1 : 0;

  state_t     r_state, w_state_nxt;
  smag_t      r_a, r_b, w_a_nxt, w_b_nxt;
  smag_t      w_opnd_cur, w_opnd_upd;
  logic       w_opnd_we, w_is_b;
  logic [2:0] r_op, w_op_nxt;
  logic [8:0] r_result, w_result_nxt;
  logic       r_result_valid, w_result_valid_nxt;
  logic       r_power, w_power_nxt;
  logic       w_key_power, w_key_digit, w_key_neg, w_key_other;
  logic       w_tmr_load, w_tmr_count, w_tmr_done;
  logic [CNT_W-1:0] w_tmr_val;

  assign w_key_power = cmd_valid && (cmd == KEY_POWER);
  assign w_key_digit = cmd_valid && is_digit(cmd);
  assign w_key_neg   = cmd_valid && (cmd == KEY_NEG);
  assign w_key_other = cmd_valid && is_command(cmd);

  assign w_is_b     = (r_state == ST_B_TENS) || (r_state == ST_B_UNITS) || (r_state == ST_B_SIGN);
  assign w_opnd_cur = w_is_b ? r_b : r_a;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_OFF;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_key_power) begin
      w_state_nxt = (r_state == ST_OFF) ? ST_IDLE : ST_OFF;
    end else begin
      case (r_state)
        ST_OFF: ;
        ST_IDLE: begin
          if (cmd_valid) begin
            case (cmd)
              KEY_SEL_A, KEY_CLEAR: w_state_nxt = ST_A_TENS;
              KEY_SEL_B:            w_state_nxt = ST_B_TENS;
              KEY_ADD, KEY_SUB:     w_state_nxt = ST_EXEC_WAIT;
              default: ;
            endcase
          end
        end
        ST_A_TENS:    if (w_key_digit) w_state_nxt = ST_A_UNITS;
        ST_A_UNITS:   if (w_key_digit || w_tmr_done) w_state_nxt = ST_A_SIGN;
        ST_A_SIGN:    if (w_key_other) w_state_nxt = ST_IDLE;
        ST_B_TENS:    if (w_key_digit) w_state_nxt = ST_B_UNITS;
        ST_B_UNITS:   if (w_key_digit || w_tmr_done) w_state_nxt = ST_B_SIGN;
        ST_B_SIGN:    if (w_key_other) w_state_nxt = ST_IDLE;
        ST_EXEC_WAIT: if (w_tmr_done) w_state_nxt = ST_IDLE;
        default:      w_state_nxt = ST_OFF;
      endcase
    end
  end

  // Next values of the registered outputs and timer control.
  always_comb begin
    w_a_nxt            = r_a;
    w_b_nxt            = r_b;
    w_op_nxt           = r_op;
    w_result_nxt       = r_result;
    w_result_valid_nxt = 1'b0;
    w_power_nxt        = r_power;
    w_opnd_upd         = w_opnd_cur;
    w_opnd_we          = 1'b0;
    w_tmr_load         = 1'b0;
    w_tmr_val          = '0;
    w_tmr_count        = (r_state == ST_A_UNITS) || (r_state == ST_B_UNITS) ||
                         (r_state == ST_EXEC_WAIT);
    if (w_key_power) begin
      if (r_state == ST_OFF) begin
        w_power_nxt = 1'b1;
        w_a_nxt     = OPND_ZERO;
        w_b_nxt     = OPND_ZERO;
        w_op_nxt    = ALU_ADD;
      end else begin
        w_power_nxt = 1'b0;
        w_a_nxt     = OPND_BLANK;
        w_b_nxt     = OPND_BLANK;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            case (cmd)
              KEY_SEL_A: w_a_nxt = OPND_ZERO;
              KEY_SEL_B: w_b_nxt = OPND_ZERO;
              KEY_CLEAR: begin
                w_a_nxt      = OPND_ZERO;
                w_b_nxt      = OPND_ZERO;
                w_result_nxt = '0;
              end
              KEY_ADD, KEY_SUB: begin
                w_op_nxt   = (cmd == KEY_ADD) ? ALU_ADD : ALU_SUB;
                w_tmr_load = 1'b1;
                w_tmr_val  = CNT_W'(ALU_LATENCY);
              end
              default: ;
            endcase
          end
        end
        ST_A_TENS, ST_B_TENS: begin
          if (w_key_digit) begin
            w_opnd_upd = smag_first(cmd[3:0]);
            w_opnd_we  = 1'b1;
            w_tmr_load = 1'b1;
            w_tmr_val  = CNT_W'(DIGIT_LOAD);
          end
        end
        ST_A_UNITS, ST_B_UNITS: begin
          if (w_key_digit) begin
            w_opnd_upd = smag_append(w_opnd_cur, cmd[3:0]);
            w_opnd_we  = 1'b1;
          end
        end
        ST_A_SIGN, ST_B_SIGN: begin
          if (w_key_neg) begin
            w_opnd_upd = smag_negate(w_opnd_cur);
            w_opnd_we  = 1'b1;
          end
        end
        ST_EXEC_WAIT: begin
          if (w_tmr_done) begin
            w_result_nxt       = alu_result;
            w_result_valid_nxt = 1'b1;
          end
        end
        default: ;
      endcase
      if (w_opnd_we) begin
        if (w_is_b) w_b_nxt = w_opnd_upd;
        else        w_a_nxt = w_opnd_upd;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a            <= OPND_BLANK;
      r_b            <= OPND_BLANK;
      r_op           <= ALU_ADD;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_power        <= 1'b0;
    end else begin
      r_a            <= w_a_nxt;
      r_b            <= w_b_nxt;
      r_op           <= w_op_nxt;
      r_result       <= w_result_nxt;
      r_result_valid <= w_result_valid_nxt;
      r_power        <= w_power_nxt;
    end
  end

  calc_wait_timer #(
    .CNT_W (CNT_W)
  ) u_wait_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_count    (w_tmr_count),
    .o_done_c   (w_tmr_done)
  );

  assign operand_a    = r_a;
  assign operand_b    = r_b;
  assign alu_op       = r_op;
  assign result       = r_result;
  assign result_valid = r_result_valid;
  assign power_on     = r_power;
  assign state_dbg    = r_state;

endmodule

// File: doc/calc_key_sequencer.md
CALC_KEY_SEQUENCER -- requirements
Module: calc_key_sequencer

Interface
REQ-001 The block SHALL have parameter DIGIT_TIMEOUT, default 50000000, meaning the cycles allowed between tens digit and units digit.
REQ-002 The block SHALL have parameter ALU_LATENCY, default 2, meaning the cycles from alu_op/operand update to a stable alu_result.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port cmd_valid, input, 1 bit: one-cycle strobe marking a new verified remote key code.
REQ-006 The block SHALL have port cmd, input, 8 bits: key code, sampled only when cmd_valid=1.
REQ-007 The block SHALL have port alu_result, input, 9 bits: result from the shared ALU.
REQ-008 The block SHALL have port operand_a, output, 8 bits: sign-magnitude, where [7] is sign and [6:0] is magnitude; 8'hFF means blank.
REQ-009 The block SHALL have port operand_b, output, 8 bits: same encoding as operand_a.
REQ-010 The block SHALL have port alu_op, output, 3 bits: 0 = add, 1 = sub.
REQ-011 The block SHALL have port result, output, 9 bits: latched ALU result.
REQ-012 The block SHALL have port result_valid, output, 1 bit: one-cycle pulse when result updates.
REQ-013 The block SHALL have port power_on, output, 1 bit: display/BCD enable.
REQ-014 The block SHALL have port state_dbg, output, 4 bits: current state encoding.

Function
REQ-015 Key codes SHALL be: digits 0x00-0x09, NEG 0x0D, SEL_A 0x0F, CLEAR 0x10, POWER 0x12, SEL_B 0x13, ADD 0x1A, SUB 0x1E; all other codes are ignored.
REQ-016 The states SHALL be OFF, IDLE, A_TENS, A_UNITS, A_SIGN, B_TENS, B_UNITS, B_SIGN, EXEC_WAIT.
REQ-017 Each cmd_valid pulse SHALL be consumed by exactly one transition; a held cmd level SHALL never re-trigger.
REQ-018 In OFF, POWER SHALL set power_on=1, set operands to 0, set alu_op=0, and go to IDLE.
REQ-019 In any state other than OFF, POWER SHALL go to OFF with power_on=0 and both operands at 8'hFF, including during EXEC_WAIT.
REQ-020 In IDLE, SEL_A SHALL zero operand_a and go to A_TENS; SEL_B SHALL do the same for operand_b and go to B_TENS.
REQ-021 In IDLE, CLEAR SHALL zero both operands and result and go to A_TENS.
REQ-022 In IDLE, ADD or SUB SHALL set alu_op and go to EXEC_WAIT.
REQ-023 In x_TENS, a digit d SHALL set magnitude=d, sign=0, and go to x_UNITS; non-digits are ignored.
REQ-024 In x_UNITS, a digit u SHALL set magnitude=10*d+u (max 99) and go to x_SIGN.
REQ-025 In x_UNITS, if no digit arrives within DIGIT_TIMEOUT cycles, the operand SHALL stay d and the block SHALL go to x_SIGN.
REQ-026 In x_UNITS, non-digits SHALL be ignored without resetting the timer.
REQ-027 In x_SIGN, NEG SHALL toggle bit [7] and go to IDLE; any other non-digit SHALL go to IDLE and be dropped; digits are ignored.
REQ-028 An operand with magnitude 0 SHALL always have sign 0, so negative zero normalizes to +0.
REQ-029 EXEC_WAIT SHALL hold for ALU_LATENCY cycles, then latch alu_result into result, pulse result_valid for one cycle, and return to IDLE.
REQ-030 Any cmd_valid during EXEC_WAIT other than POWER SHALL be dropped.
REQ-031 Operands SHALL change only in the states listed above; alu_op SHALL be stable outside REQ-018 and REQ-022.

Reset
REQ-032 Asserting rst SHALL immediately force: state OFF, power_on=0, operand_a=operand_b=8'hFF, alu_op=0, result=0, result_valid=0, timers 0.
REQ-033 Reset mid-operation, including mid-EXEC_WAIT, SHALL discard the pending latch.

Structure
REQ-034 The key codes, state encoding, ALU op codes and blank value 8'hFF SHALL live in the shared package calc_pkg.
REQ-035 The DIGIT_TIMEOUT and ALU_LATENCY countdown SHALL be one sub-module, calc_wait_timer (load, count, done).

Verification
REQ-036 The bench SHALL cover: reset, then POWER -> power_on=1, operands 0, state IDLE.
REQ-037 The bench SHALL cover: SEL_A, 4, 2, NEG -> operand_a=8'hAA (-42), state IDLE.
REQ-038 The bench SHALL cover: SEL_B, 7, no digit for DIGIT_TIMEOUT+1 cycles, then NEG -> operand_b=8'h87.
REQ-039 The bench SHALL cover: SEL_A, 0, 0, NEG -> operand_a=8'h00 (normalized).
REQ-040 The bench SHALL cover: ADD with stub alu_result=9'h01E -> result=0x01E and exactly one result_valid pulse ALU_LATENCY+1 cycles after ADD; a digit sent during EXEC_WAIT is ignored.
REQ-041 The bench SHALL cover: POWER in A_UNITS, and rst asserted mid-EXEC_WAIT -> OFF, operands 8'hFF, no result_valid.
